// File: rtl/mem_line_responder_pkg.sv
// Types and constants for the memory line responder, derived from the shared macros.
`ifndef MLR_DIRECTIVES_SV
`include "preprocessor_directives.sv"
`endif

package mem_line_responder_pkg;

  localparam int LINE_W   = `LINE_BITS;
  localparam int OFFSET_W = `OFFSET_BITS;
  localparam int ADDR_W   = `PHYS_ADDR_SIZE;
  // Full line index carried from the address, before any range check.
  localparam int LIDX_W   = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE = `MLR_IDLE,
    ST_BUSY = `MLR_BUSY,
    ST_RESP = `MLR_RESP
  } mlr_state_e;

  typedef struct packed {
    logic              we;
    logic              id;
    logic [LIDX_W-1:0] line;
    logic [LINE_W-1:0] wdata;
  } mlr_req_t;

endpackage

// File: rtl/mlr_storage.sv
// Single-port line storage with synchronous read and write; contents are not reset.
module mlr_storage
  import mem_line_responder_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int IDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [MEM_LINES];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/preprocessor_directives.sv
// Address/line geometry and responder state codes, shared with the cache and arbiter.
`ifndef MLR_DIRECTIVES_SV
`define MLR_DIRECTIVES_SV

`define LINE_BITS      128
`define OFFSET_BITS    4
`define PHYS_ADDR_SIZE 32

`define MLR_IDLE 2'd0
`define MLR_BUSY 2'd1
`define MLR_RESP 2'd2

`endif

// File: rtl/mem_line_responder.sv
// Fixed-latency line fill/writeback responder: accepts one request at a time and
// pulses a response LATENCY cycles after accept.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int MEM_LINES = 1024
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_id,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_id,
  output logic              resp_err,
  output logic [LINE_W-1:0] resp_rdata
);

  localparam int                IDX_W      = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam logic [LIDX_W:0]   LINE_LIMIT = (LIDX_W + 1)'(MEM_LINES);
  localparam logic [3:0]        CNT_LOAD   = 4'(LATENCY - 1);

  mlr_state_e        state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  mlr_req_t          lat, lat_nxt;
  mlr_req_t          incoming, acc;
  logic              acc_in_range, lat_in_range;
  logic              mem_en;
  logic [LINE_W-1:0] mem_rdata;
  logic              unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  always_comb begin
    incoming.we    = req_we;
    incoming.id    = req_id;
    incoming.line  = req_addr[ADDR_W-1:OFFSET_W];
    incoming.wdata = req_wdata;

    state_nxt = state;
    cnt_nxt   = cnt;
    lat_nxt   = lat;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          lat_nxt   = incoming;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // With LATENCY=1 the storage access shares the accept edge, so the live
    // request fields must be used before they reach the latch.
    acc          = (state == ST_IDLE) ? incoming : lat;
    acc_in_range = ({1'b0, acc.line} < LINE_LIMIT);
    lat_in_range = ({1'b0, lat.line} < LINE_LIMIT);
    mem_en       = (state != ST_RESP) && (state_nxt == ST_RESP) && acc_in_range && !rst;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lat   <= lat_nxt;
    end
  end

  mlr_storage #(
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_storage (
    .clock (clock),
    .en    (mem_en),
    .we    (acc.we),
    .addr  (acc.line[IDX_W-1:0]),
    .wdata (acc.wdata),
    .rdata (mem_rdata)
  );

  assign req_ready  = (state == ST_IDLE) && !rst;
  assign resp_valid = (state == ST_RESP);
  assign resp_id    = resp_valid & lat.id;
  assign resp_err   = resp_valid & !lat_in_range;
  assign resp_rdata = (resp_valid && !lat.we && lat_in_range) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized bench for mem_line_responder with a line-map reference model; one
// instance at LATENCY=5 and one at LATENCY=1.
module tb_mem_line_responder;
  import mem_line_responder_pkg::*;

  localparam int MEM_LINES = 256;
  localparam int LAT0      = 5;
  localparam int LAT1      = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              rst;
  logic              req_valid  [2];
  logic              req_we     [2];
  logic              req_id     [2];
  logic [ADDR_W-1:0] req_addr   [2];
  logic [LINE_W-1:0] req_wdata  [2];
  logic              req_ready  [2];
  logic              resp_valid [2];
  logic              resp_id    [2];
  logic              resp_err   [2];
  logic [LINE_W-1:0] resp_rdata [2];

  int total = 0;
  int bad   = 0;

  bit [LINE_W-1:0] model [longint];

  mem_line_responder #(.LATENCY(LAT0), .MEM_LINES(MEM_LINES)) dut0 (
    .clock(clock), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_id(req_id[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_id(resp_id[0]), .resp_err(resp_err[0]),
    .resp_rdata(resp_rdata[0])
  );

  mem_line_responder #(.LATENCY(LAT1), .MEM_LINES(MEM_LINES)) dut1 (
    .clock(clock), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_id(req_id[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_id(resp_id[1]), .resp_err(resp_err[1]),
    .resp_rdata(resp_rdata[1])
  );

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: memory is a map of line index -> data per instance; a line at or
  // beyond MEM_LINES is an error, reads back zero and is never stored.
  function automatic void model_step(input int sel, input bit we, input logic [ADDR_W-1:0] addr,
                                     input logic [LINE_W-1:0] wdata,
                                     output logic [LINE_W-1:0] rdata, output bit err, output bit known);
    longint line = longint'(addr >> 4);
    longint key  = longint'(sel) * 64'd1000000000 + line;
    err   = (line >= longint'(MEM_LINES));
    rdata = '0;
    known = 1'b1;
    if (!err) begin
      if (we) model[key] = wdata;
      else if (model.exists(key)) rdata = model[key];
      else known = 1'b0;
    end
  endfunction

  task automatic do_txn(input int sel, input bit we, input bit id, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wdata,
                        output logic [LINE_W-1:0] rdata, output bit err, output bit rid,
                        output int lat, output bit quiet);
    int w = 0;
    quiet = 1'b1; lat = 0; rdata = '0; err = 1'b0; rid = 1'b0;
    @(negedge clock);
    while (!req_ready[sel] && w < 50) begin
      @(negedge clock);
      w++;
    end
    req_valid[sel] = 1'b1; req_we[sel] = we; req_id[sel] = id;
    req_addr[sel]  = addr; req_wdata[sel] = wdata;
    @(posedge clock);
    #1;
    req_valid[sel] = 1'b0;
    req_we[sel]    = 1'($urandom);
    req_id[sel]    = 1'($urandom);
    req_addr[sel]  = ADDR_W'($urandom);
    req_wdata[sel] = rand_line();
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (resp_valid[sel]) break;
      if (req_ready[sel]) quiet = 1'b0;
    end
    rdata = resp_rdata[sel];
    err   = resp_err[sel];
    rid   = resp_id[sel];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_id[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    @(posedge clock);
    repeat (2) begin
      @(negedge clock);
      total++;
      if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", req_ready[0]); end
      total++;
      if ({resp_valid[0], resp_id[0], resp_err[0]} !== 3'b000) begin
        bad++; $display("FAIL reset_resp_flags got=%b exp=000", {resp_valid[0], resp_id[0], resp_err[0]});
      end
      total++;
      if (resp_rdata[0] !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata[0]); end
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clock);
      total++;
      if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
        bad++; $display("FAIL idle_after_reset got ready=%0b valid=%0b exp ready=1 valid=0", req_ready[0], resp_valid[0]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [LINE_W-1:0] d, rd, erd;
    bit err, rid, eerr, known, quiet;
    int lat;
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    model_step(0, 1'b1, 32'h40, d, erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, 32'h40, d, rd, err, rid, lat, quiet);
    total++;
    if (lat !== LAT0) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT0); end
    total++;
    if (rd !== erd || err !== eerr || rid !== 1'b0) begin
      bad++; $display("FAIL wr_resp got rdata=%h err=%0b id=%0b exp rdata=%h err=%0b id=0", rd, err, rid, erd, eerr);
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL wr_ready_busy got ready=1 in busy exp=0"); end
    model_step(0, 1'b0, 32'h4C, '0, erd, eerr, known);
    do_txn(0, 1'b0, 1'b1, 32'h4C, rand_line(), rd, err, rid, lat, quiet);
    total++;
    if (rd !== d || rd !== erd) begin bad++; $display("FAIL rd_after_wr got=%h exp=%h", rd, d); end
    total++;
    if (rid !== 1'b1 || err !== 1'b0 || lat !== LAT0) begin
      bad++; $display("FAIL rd_after_wr_meta got id=%0b err=%0b lat=%0d exp id=1 err=0 lat=%0d", rid, err, lat, LAT0);
    end
  endtask

  task automatic test_latency1();
    logic [LINE_W-1:0] d, rd, erd;
    bit err, rid, eerr, known, quiet;
    int lat;
    d = rand_line();
    model_step(1, 1'b1, 32'h100, d, erd, eerr, known);
    do_txn(1, 1'b1, 1'b1, 32'h100, d, rd, err, rid, lat, quiet);
    model_step(1, 1'b0, 32'h105, '0, erd, eerr, known);
    do_txn(1, 1'b0, 1'b0, 32'h105, '0, rd, err, rid, lat, quiet);
    total++;
    if (lat !== LAT1) begin bad++; $display("FAIL lat1_latency got=%0d exp=%0d", lat, LAT1); end
    total++;
    if (rd !== erd || err !== 1'b0 || rid !== 1'b0) begin
      bad++; $display("FAIL lat1_read got rdata=%h err=%0b id=%0b exp rdata=%h err=0 id=0", rd, err, rid, erd);
    end
    @(negedge clock);
    total++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
      bad++; $display("FAIL lat1_after_resp got ready=%0b valid=%0b exp ready=1 valid=0", req_ready[1], resp_valid[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] a, b, rd, erd;
    bit err, rid, eerr, known, quiet;
    int lat;
    int acc[$];
    bit ids[$];
    logic [LINE_W-1:0] rds[$];
    a = rand_line(); b = rand_line();
    model_step(0, 1'b1, 32'h200, a, erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, 32'h200, a, rd, err, rid, lat, quiet);
    model_step(0, 1'b1, 32'h210, b, erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, 32'h210, b, rd, err, rid, lat, quiet);
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_id[0] = 1'b0; req_addr[0] = 32'h200;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clock);
      if (resp_valid[0]) begin ids.push_back(resp_id[0]); rds.push_back(resp_rdata[0]); end
      if (req_valid[0] && req_ready[0]) begin
        acc.push_back(k);
        @(posedge clock);
        #1;
        if (acc.size() == 1) begin req_id[0] = 1'b1; req_addr[0] = 32'h210; end
        else req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    total++;
    if (acc.size() !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc.size()); end
    else begin
      total++;
      if (acc[1] - acc[0] !== LAT0 + 1) begin
        bad++; $display("FAIL b2b_gap got=%0d exp=%0d", acc[1] - acc[0], LAT0 + 1);
      end
    end
    total++;
    if (ids.size() !== 2) begin bad++; $display("FAIL b2b_responses got=%0d exp=2", ids.size()); end
    else begin
      total++;
      if (ids[0] !== 1'b0 || ids[1] !== 1'b1) begin
        bad++; $display("FAIL b2b_ids got=%0b%0b exp=01", ids[0], ids[1]);
      end
      total++;
      if (rds[0] !== a || rds[1] !== b) begin
        bad++; $display("FAIL b2b_rdata got=%h/%h exp=%h/%h", rds[0], rds[1], a, b);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [LINE_W-1:0] z, rd, erd;
    bit err, rid, eerr, known, quiet;
    int lat;
    logic [ADDR_W-1:0] oob;
    z   = rand_line();
    oob = ADDR_W'(MEM_LINES * 16);
    model_step(0, 1'b1, 32'h0, z, erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, 32'h0, z, rd, err, rid, lat, quiet);
    model_step(0, 1'b0, oob, '0, erd, eerr, known);
    do_txn(0, 1'b0, 1'b1, oob, '0, rd, err, rid, lat, quiet);
    total++;
    if (err !== 1'b1 || rd !== '0 || rid !== 1'b1) begin
      bad++; $display("FAIL oob_read got err=%0b rdata=%h id=%0b exp err=1 rdata=0 id=1", err, rd, rid);
    end
    model_step(0, 1'b1, oob, rand_line(), erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, oob, rand_line(), rd, err, rid, lat, quiet);
    total++;
    if (err !== 1'b1 || lat !== LAT0) begin
      bad++; $display("FAIL oob_write got err=%0b lat=%0d exp err=1 lat=%0d", err, lat, LAT0);
    end
    model_step(0, 1'b0, 32'h8000_0000, '0, erd, eerr, known);
    do_txn(0, 1'b0, 1'b0, 32'h8000_0000, '0, rd, err, rid, lat, quiet);
    total++;
    if (err !== 1'b1 || rd !== '0) begin
      bad++; $display("FAIL oob_high_bit got err=%0b rdata=%h exp err=1 rdata=0", err, rd);
    end
    model_step(0, 1'b0, 32'h8, '0, erd, eerr, known);
    do_txn(0, 1'b0, 1'b0, 32'h8, '0, rd, err, rid, lat, quiet);
    total++;
    if (rd !== erd || rd !== z || err !== 1'b0) begin
      bad++; $display("FAIL oob_line0_intact got=%h err=%0b exp=%h err=0", rd, err, z);
    end
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] p, rd, erd;
    bit err, rid, eerr, known, quiet, seen;
    int lat, w;
    p = rand_line();
    model_step(0, 1'b1, 32'h80, p, erd, eerr, known);
    do_txn(0, 1'b1, 1'b0, 32'h80, p, rd, err, rid, lat, quiet);
    w = 0;
    @(negedge clock);
    while (!req_ready[0] && w < 50) begin @(negedge clock); w++; end
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_id[0] = 1'b1;
    req_addr[0] = 32'h80; req_wdata[0] = ~p;
    @(posedge clock);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (resp_valid[0]) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_resp got valid=1 exp=0"); end
    model_step(0, 1'b0, 32'h80, '0, erd, eerr, known);
    do_txn(0, 1'b0, 1'b0, 32'h80, '0, rd, err, rid, lat, quiet);
    total++;
    if (rd !== erd || rd !== p) begin bad++; $display("FAIL rst_mid_preserved got=%h exp=%h", rd, p); end
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] wd, rd, erd;
    logic [ADDR_W-1:0] a;
    bit we, id, err, rid, eerr, known, quiet;
    int lat, r;
    for (int n = 0; n < 24; n++) begin
      r  = int'($urandom_range(9, 0));
      we = 1'($urandom);
      id = 1'($urandom);
      wd = rand_line();
      if (r < 8) a = ADDR_W'(32'h300 + (r << 4) + $urandom_range(15, 0));
      else if (r == 8) a = ADDR_W'(MEM_LINES * 16 + $urandom_range(255, 0));
      else begin a = ADDR_W'($urandom); a[ADDR_W-1] = 1'b1; end
      model_step(0, we, a, wd, erd, eerr, known);
      do_txn(0, we, id, a, wd, rd, err, rid, lat, quiet);
      total++;
      if (err !== eerr || rid !== id || lat !== LAT0 || !quiet) begin
        bad++; $display("FAIL rand_meta n=%0d addr=%h got err=%0b id=%0b lat=%0d quiet=%0b exp err=%0b id=%0b lat=%0d quiet=1",
                        n, a, err, rid, lat, quiet, eerr, id, LAT0);
      end
      if (known) begin
        total++;
        if (rd !== erd) begin bad++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, rd, erd); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_latency1();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
